// File: rtl/zap_wb_arb_pkg.sv
// Shared types and constants for the zap Wishbone B3 round-robin arbiter.
// Optional watchdog feature is selected by the ZAP_WB_ARB_TIMEOUT_EN macro.
package zap_wb_arb_pkg;

  // Arbiter states; ARB_ABORT is only reachable when the watchdog is built in.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_e;

  // Wishbone B3 cycle type identifiers.
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Bus widths.
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  localparam int WB_CTI_W = 3;

endpackage

// File: rtl/zap_rr_picker.sv
// Combinational round-robin selector: scans upward from ptr_i+1 with
// wrap-around and returns the first requester as one-hot and as an index.
module zap_rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Priority scan starting just after the last winner.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zap_wb_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one slave bus between NUM_MASTERS
// requesters. Grant is held for the whole cyc tenure so bursts are never split.
// Define ZAP_WB_ARB_TIMEOUT_EN to build the watchdog that aborts a cycle whose
// slave never acknowledges (TIMEOUT_CYCLES stb cycles).
module zap_wb_arbiter
  import zap_wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [NUM_MASTERS-1:0]          i_m_cyc,
  input  logic [NUM_MASTERS-1:0]          i_m_stb,
  input  logic [NUM_MASTERS-1:0]          i_m_we,
  input  logic [NUM_MASTERS*WB_ADR_W-1:0] i_m_adr,
  input  logic [NUM_MASTERS*WB_DAT_W-1:0] i_m_dat,
  input  logic [NUM_MASTERS*WB_SEL_W-1:0] i_m_sel,
  input  logic [NUM_MASTERS*WB_CTI_W-1:0] i_m_cti,
  output logic [NUM_MASTERS-1:0]          o_m_ack,
  output logic [NUM_MASTERS-1:0]          o_m_err,
  output logic [WB_DAT_W-1:0]             o_m_dat,
  output logic                            o_wb_cyc,
  output logic                            o_wb_stb,
  output logic                            o_wb_we,
  output logic [WB_ADR_W-1:0]             o_wb_adr,
  output logic [WB_DAT_W-1:0]             o_wb_dat,
  output logic [WB_SEL_W-1:0]             o_wb_sel,
  output logic [WB_CTI_W-1:0]             o_wb_cti,
  input  logic                            i_wb_ack,
  input  logic [WB_DAT_W-1:0]             i_wb_dat,
  output logic [NUM_MASTERS-1:0]          o_gnt,
  output logic                            o_busy
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [IDX_W-1:0]       ptr_q;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic [NUM_MASTERS-1:0] mux_en;
  logic                   owner_cyc;

  zap_rr_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i   (i_m_cyc),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // The granted master still holds its bus cycle open.
  assign owner_cyc = |(i_m_cyc & gnt_q);

  // Only a GRANT state drives the slave bus and routes acks.
  assign mux_en = (state_q == ARB_GRANT) ? gnt_q : '0;

`ifdef ZAP_WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_MASTERS-1:0] err_q;
  logic                   timeout_hit;

  assign timeout_hit = (state_q == ARB_GRANT) && o_wb_stb && !i_wb_ack &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: count unacknowledged strobe cycles of the current tenure.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (state_q != ARB_GRANT || i_wb_ack || !owner_cyc || timeout_hit) begin
      cnt_q <= '0;
    end else if (o_wb_stb) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_m_err = err_q;
`else
  assign o_m_err = '0;
`endif

  // Arbitration FSM with registered grant (and error pulse when built in).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      ptr_q   <= IDX_W'(NUM_MASTERS - 1);
`ifdef ZAP_WB_ARB_TIMEOUT_EN
      err_q   <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
`ifdef ZAP_WB_ARB_TIMEOUT_EN
      err_q <= '0;
`endif
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            gnt_q   <= pick_gnt;
            ptr_q   <= pick_idx;
            state_q <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (!owner_cyc) begin
            gnt_q   <= '0;
            state_q <= ARB_IDLE;
          end
`ifdef ZAP_WB_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            err_q   <= gnt_q;
            state_q <= ARB_ABORT;
          end
`endif
        end
`ifdef ZAP_WB_ARB_TIMEOUT_EN
        ARB_ABORT: begin
          if (!owner_cyc) begin
            gnt_q   <= '0;
            state_q <= ARB_IDLE;
          end
        end
`endif
        default: begin
          gnt_q   <= '0;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  // AND-OR mux of the granted master's request onto the slave bus.
  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_we  = 1'b0;
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_sel = '0;
    o_wb_cti = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (mux_en[k]) begin
        o_wb_cyc = o_wb_cyc | i_m_cyc[k];
        o_wb_stb = o_wb_stb | i_m_stb[k];
        o_wb_we  = o_wb_we  | i_m_we[k];
        o_wb_adr = o_wb_adr | i_m_adr[k*WB_ADR_W +: WB_ADR_W];
        o_wb_dat = o_wb_dat | i_m_dat[k*WB_DAT_W +: WB_DAT_W];
        o_wb_sel = o_wb_sel | i_m_sel[k*WB_SEL_W +: WB_SEL_W];
        o_wb_cti = o_wb_cti | i_m_cti[k*WB_CTI_W +: WB_CTI_W];
      end
    end
  end

  assign o_m_ack = mux_en & {NUM_MASTERS{i_wb_ack}};
  assign o_m_dat = i_wb_dat;
  assign o_gnt   = gnt_q;
  assign o_busy  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Directed bench for zap_wb_arbiter with two masters and TIMEOUT_CYCLES = 16.
module tb_zap_wb_arbiter;
  import zap_wb_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
  logic [63:0] m_adr = '0, m_dat = '0;
  logic [7:0]  m_sel = '0;
  logic [5:0]  m_cti = '0;
  logic [1:0]  m_ack, m_err;
  logic [31:0] m_rdat;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic        wb_ack = 1'b0;
  logic [31:0] wb_rdat = '0;
  logic [1:0]  gnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zap_wb_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel), .i_m_cti(m_cti),
    .o_m_ack(m_ack), .o_m_err(m_err), .o_m_dat(m_rdat),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_cti(wb_cti),
    .i_wb_ack(wb_ack), .i_wb_dat(wb_rdat),
    .o_gnt(gnt), .o_busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int k, input logic cyc, input logic we,
                         input logic [31:0] adr, input logic [2:0] cti);
    m_cyc[k]         = cyc;
    m_stb[k]         = cyc;
    m_we[k]          = we;
    m_adr[k*32 +: 32] = adr;
    m_dat[k*32 +: 32] = adr ^ 32'hA5A5_0000;
    m_sel[k*4 +: 4]   = 4'hF;
    m_cti[k*3 +: 3]   = cti;
  endtask

  task automatic idle_all();
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_cti = '0;
    wb_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (gnt !== 2'b00)   begin errors++; $display("FAIL rst_gnt: got %b exp 00", gnt); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
    checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL rst_wb_cyc: got %b exp 0", wb_cyc); end
    checks++; if (wb_adr !== 32'h0) begin errors++; $display("FAIL rst_wb_adr: got %h exp 0", wb_adr); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL rst_ack: got %b exp 00", m_ack); end
    checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL rst_err: got %b exp 00", m_err); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    drive_m(0, 1'b1, 1'b0, 32'h100, CTI_CLASSIC);
    #1;
    checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL rd_latency: wb_cyc got %b exp 0", wb_cyc); end
    tick();
    checks++; if (gnt !== 2'b01)       begin errors++; $display("FAIL rd_gnt: got %b exp 01", gnt); end
    checks++; if (wb_cyc !== 1'b1)     begin errors++; $display("FAIL rd_wb_cyc: got %b exp 1", wb_cyc); end
    checks++; if (wb_adr !== 32'h100)  begin errors++; $display("FAIL rd_wb_adr: got %h exp 100", wb_adr); end
    checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL rd_busy: got %b exp 1", busy); end
    checks++; if (m_ack !== 2'b00)     begin errors++; $display("FAIL rd_no_early_ack: got %b exp 00", m_ack); end
    tick();
    tick();
    wb_ack  = 1'b1;
    wb_rdat = 32'hDEADBEEF;
    #1;
    checks++; if (m_ack !== 2'b01)        begin errors++; $display("FAIL rd_ack: got %b exp 01", m_ack); end
    checks++; if (m_rdat !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_dat: got %h exp deadbeef", m_rdat); end
    tick();
    drive_m(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    wb_ack = 1'b0;
    #1;
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL rd_ack_len: got %b exp 00", m_ack); end
    checks++; if (gnt !== 2'b01)   begin errors++; $display("FAIL rd_hold: got %b exp 01", gnt); end
    tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rd_release_gnt: got %b exp 00", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_release_busy: got %b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    do_reset();
    drive_m(0, 1'b1, 1'b0, 32'h100, CTI_CLASSIC);
    drive_m(1, 1'b1, 1'b0, 32'h200, CTI_CLASSIC);
    tick();
    checks++; if (gnt !== 2'b01)      begin errors++; $display("FAIL rr_first: got %b exp 01", gnt); end
    checks++; if (wb_adr !== 32'h100) begin errors++; $display("FAIL rr_first_adr: got %h exp 100", wb_adr); end
    wb_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL rr_ack_route: got %b exp 01", m_ack); end
    wb_ack = 1'b0;
    drive_m(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rr_gap: got %b exp 00", gnt); end
    tick();
    checks++; if (gnt !== 2'b10)      begin errors++; $display("FAIL rr_second: got %b exp 10", gnt); end
    checks++; if (wb_adr !== 32'h200) begin errors++; $display("FAIL rr_second_adr: got %h exp 200", wb_adr); end
    drive_m(0, 1'b1, 1'b0, 32'h104, CTI_CLASSIC);
    tick();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rr_no_preempt: got %b exp 10", gnt); end
    drive_m(1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rr_gap2: got %b exp 00", gnt); end
    tick();
    checks++; if (gnt !== 2'b01)      begin errors++; $display("FAIL rr_repeat: got %b exp 01", gnt); end
    checks++; if (wb_adr !== 32'h104) begin errors++; $display("FAIL rr_repeat_adr: got %h exp 104", wb_adr); end
    drive_m(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    tick();
    tick();
  endtask

  task automatic test_burst();
    logic [2:0] exp_cti;
    drive_m(0, 1'b1, 1'b0, 32'h1000, CTI_INCR);
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL bu_gnt: got %b exp 01", gnt); end
    drive_m(1, 1'b1, 1'b0, 32'h2000, CTI_CLASSIC);
    for (int b = 0; b < 4; b++) begin
      exp_cti = (b == 3) ? CTI_EOB : CTI_INCR;
      drive_m(0, 1'b1, 1'b0, 32'h1000 + 32'(4 * b), exp_cti);
      wb_ack = 1'b1;
      #1;
      checks++; if (gnt !== 2'b01)    begin errors++; $display("FAIL bu_beat%0d_gnt: got %b exp 01", b, gnt); end
      checks++; if (wb_cti !== exp_cti) begin errors++; $display("FAIL bu_beat%0d_cti: got %b exp %b", b, wb_cti, exp_cti); end
      checks++; if (wb_adr !== 32'h1000 + 32'(4 * b)) begin errors++; $display("FAIL bu_beat%0d_adr: got %h exp %h", b, wb_adr, 32'h1000 + 32'(4 * b)); end
      checks++; if (m_ack !== 2'b01)  begin errors++; $display("FAIL bu_beat%0d_ack: got %b exp 01", b, m_ack); end
      tick();
    end
    drive_m(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    wb_ack = 1'b0;
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL bu_hold_end: got %b exp 01", gnt); end
    tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL bu_gap: got %b exp 00", gnt); end
    tick();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL bu_next: got %b exp 10", gnt); end
    drive_m(1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    tick();
    tick();
  endtask

  task automatic test_reset_mid_write();
    drive_m(0, 1'b1, 1'b1, 32'h300, CTI_CLASSIC);
    tick();
    checks++; if (gnt !== 2'b01)  begin errors++; $display("FAIL mr_gnt: got %b exp 01", gnt); end
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL mr_we: got %b exp 1", wb_we); end
    wb_ack = 1'b1;
    rst    = 1'b1;
    #1;
    checks++; if (wb_cyc !== 1'b0)  begin errors++; $display("FAIL mr_wb_cyc: got %b exp 0", wb_cyc); end
    checks++; if (wb_we !== 1'b0)   begin errors++; $display("FAIL mr_wb_we: got %b exp 0", wb_we); end
    checks++; if (wb_adr !== 32'h0) begin errors++; $display("FAIL mr_wb_adr: got %h exp 0", wb_adr); end
    checks++; if (gnt !== 2'b00)    begin errors++; $display("FAIL mr_gnt_clr: got %b exp 00", gnt); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL mr_busy: got %b exp 0", busy); end
    checks++; if (m_ack !== 2'b00)  begin errors++; $display("FAIL mr_ack: got %b exp 00", m_ack); end
    wb_ack = 1'b0;
    drive_m(1, 1'b1, 1'b0, 32'h400, CTI_CLASSIC);
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL mr_first_after: got %b exp 01", gnt); end
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_hung_slave();
    do_reset();
    drive_m(0, 1'b1, 1'b0, 32'h500, CTI_CLASSIC);
    drive_m(1, 1'b1, 1'b0, 32'h600, CTI_CLASSIC);
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL hg_gnt: got %b exp 01", gnt); end
`ifdef ZAP_WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL to_early_err%0d: got %b exp 00", i, m_err); end
      checks++; if (wb_cyc !== 1'b1) begin errors++; $display("FAIL to_cyc%0d: got %b exp 1", i, wb_cyc); end
      tick();
    end
    checks++; if (m_err !== 2'b01) begin errors++; $display("FAIL to_err: got %b exp 01", m_err); end
    checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL to_abort_cyc: got %b exp 0", wb_cyc); end
    checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL to_abort_busy: got %b exp 1", busy); end
    tick();
    checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL to_err_len: got %b exp 00", m_err); end
    checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL to_abort_cyc2: got %b exp 0", wb_cyc); end
    drive_m(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got %b exp 0", busy); end
`else
    for (int i = 0; i < 20; i++) begin
      checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL nt_err%0d: got %b exp 00", i, m_err); end
      checks++; if (gnt !== 2'b01)   begin errors++; $display("FAIL nt_hold%0d: got %b exp 01", i, gnt); end
      checks++; if (wb_cyc !== 1'b1) begin errors++; $display("FAIL nt_cyc%0d: got %b exp 1", i, wb_cyc); end
      tick();
    end
    drive_m(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL nt_gap: got %b exp 00", gnt); end
`endif
    tick();
    checks++; if (gnt !== 2'b10)      begin errors++; $display("FAIL hg_next: got %b exp 10", gnt); end
    checks++; if (wb_adr !== 32'h600) begin errors++; $display("FAIL hg_next_adr: got %h exp 600", wb_adr); end
    idle_all();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst();
    test_reset_mid_write();
    test_hung_slave();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
